// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter: round-robin sequencer sharing one combinational 4-operand FP32 adder among requesters
module fp_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CTRL_W  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ*32-1:0] req_c,
    input  logic [NUM_REQ*32-1:0] req_d,
    input  logic [NUM_REQ*3-1:0]  req_subop,
    input  logic [NUM_REQ*3-1:0]  req_rm,
    input  logic [CTRL_W-1:0]     ctrl_cfg,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    output logic [31:0]           add_c,
    output logic [31:0]           add_d,
    output logic [2:0]            add_subop,
    output logic [2:0]            add_rm,
    output logic [CTRL_W-1:0]     add_control,
    input  logic [31:0]           add_out,
    input  logic [4:0]            add_flags,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic [4:0]            rsp_flags,
    output logic [4:0]            sticky_flags,
    input  logic                  flags_clr,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;
    stateT state, stateNext;
    logic [ID_W-1:0] rrPtr, idReg, grantId;
    logic [NUM_REQ-1:0] grantOh;
    logic found, window, grant, rspFire;
    logic [31:0] opA, opB, opC, opD, resData;
    logic [2:0] opSubop, opRm;
    logic [4:0] resFlags, sticky;

    // Scan requesters starting just after the last winner; first valid one wins
    always_comb begin
        grantOh = '0;
        grantId = rrPtr;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rrPtr) + k) % NUM_REQ]) begin
                found = 1'b1;
                grantId = ID_W'((int'(rrPtr) + k) % NUM_REQ);
                grantOh[(int'(rrPtr) + k) % NUM_REQ] = 1'b1;
            end
        end
    end

    // A new op may start when idle, or when the pending response leaves this cycle
    assign window    = rst_n && (state == IDLE || (state == RESP && rsp_ready));
    assign grant     = window && found;
    assign rspFire   = state == RESP && rsp_ready;
    assign req_ready = window ? grantOh : '0;

    // Next-state: EXEC always lasts one cycle; RESP waits for the consumer
    always_comb begin
        stateNext = state;
        stateNext = (state == EXEC) ? RESP :
                    grant ? EXEC :
                    (state == RESP && !rsp_ready) ? RESP : IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= stateNext;
    end

    // Capture the winner's operands, id and round-robin position on grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opA <= '0;
            opB <= '0;
            opC <= '0;
            opD <= '0;
            opSubop <= '0;
            opRm <= '0;
            idReg <= '0;
            rrPtr <= ID_W'(NUM_REQ - 1);
        end else if (grant) begin
            opA <= req_a[int'(grantId)*32 +: 32];
            opB <= req_b[int'(grantId)*32 +: 32];
            opC <= req_c[int'(grantId)*32 +: 32];
            opD <= req_d[int'(grantId)*32 +: 32];
            opSubop <= req_subop[int'(grantId)*3 +: 3];
            opRm <= req_rm[int'(grantId)*3 +: 3];
            idReg <= grantId;
            rrPtr <= grantId;
        end
    end

    // Register the adder result at the end of EXEC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resData <= '0;
            resFlags <= '0;
        end else if (state == EXEC) begin
            resData <= add_out;
            resFlags <= add_flags;
        end
    end

    // Sticky flags accumulate accepted responses; a clear keeps only the current handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky <= '0;
        else sticky <= flags_clr ? (rspFire ? resFlags : 5'b0) : (rspFire ? sticky | resFlags : sticky);
    end

    assign add_a        = opA;
    assign add_b        = opB;
    assign add_c        = opC;
    assign add_d        = opD;
    assign add_subop    = opSubop;
    assign add_rm       = opRm;
    assign add_control  = ctrl_cfg;
    assign rsp_valid    = state == RESP;
    assign rsp_id       = idReg;
    assign rsp_data     = resData;
    assign rsp_flags    = resFlags;
    assign sticky_flags = sticky;
    assign busy         = state != IDLE;
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// tb_fp_adder_arbiter: scoreboard bench for the shared-adder round-robin sequencer
module tb_fp_adder_arbiter;
    localparam int N = 4;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [N-1:0] req_valid = '0, req_ready;
    logic [N*32-1:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic [N*3-1:0] req_subop = '0, req_rm = '0;
    logic [0:0] ctrl_cfg = 1'b1, add_control;
    logic [31:0] add_a, add_b, add_c, add_d, add_out, rsp_data;
    logic [2:0] add_subop, add_rm;
    logic [4:0] add_flags, rsp_flags, sticky_flags;
    logic rsp_valid, rsp_ready = 1'b1, flags_clr = 1'b0, busy;
    logic [1:0] rsp_id;

    fp_adder_arbiter #(.NUM_REQ(N), .ID_W(2), .CTRL_W(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_d(req_d),
        .req_subop(req_subop), .req_rm(req_rm), .ctrl_cfg(ctrl_cfg),
        .add_a(add_a), .add_b(add_b), .add_c(add_c), .add_d(add_d),
        .add_subop(add_subop), .add_rm(add_rm), .add_control(add_control),
        .add_out(add_out), .add_flags(add_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .sticky_flags(sticky_flags), .flags_clr(flags_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in adder: exact results for the directed vectors, a deterministic mix otherwise
    function automatic logic [36:0] refAdd(input logic [31:0] a, b, c, d, input logic [2:0] s, r);
        logic [31:0] x;
        x = a ^ b ^ c ^ d;
        if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h40400000 && d == 32'h40800000 && s == 3'd0 && r == 3'd0)
            return {5'b00000, 32'h41200000};
        if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF && c == 32'd0 && d == 32'd0 && r == 3'd0)
            return {5'b00101, 32'h7F800000};
        if (a == 32'h33333333) return {5'b00001, a ^ b};
        return {x[4:0] ^ {r, s[1:0]}, a + b + c + d + {29'd0, s}};
    endfunction

    always_comb {add_flags, add_out} = refAdd(add_a, add_b, add_c, add_d, add_subop, add_rm);

    typedef struct { int id; logic [31:0] a, b, c, d; logic [2:0] s, r; } opT;
    opT q[$];
    opT last, rec;
    int tests = 0, fails = 0, ptr = N - 1, age = 0, winner, cycle = 0;
    int dutGrants[$], grantCycles[$];
    logic [N-1:0] grantMask = '0, expReady;
    logic [4:0] sticky = '0;
    logic [36:0] expRes;
    logic inflight, expRsp, window;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Monitor: predicts every output from the requests seen so far and pops responses
    always @(negedge clk) begin
        cycle++;
        if (!rst_n) begin
            check("rstRspValid", 64'(rsp_valid), 64'(0));
            check("rstReqReady", 64'(req_ready), 64'(0));
            check("rstBusy", 64'(busy), 64'(0));
            check("rstAddA", 64'(add_a), 64'(0));
            check("rstAddD", 64'(add_d), 64'(0));
            q.delete();
            ptr = N - 1;
            age = 0;
            sticky = '0;
            last = '{default: 0};
            grantMask = '0;
        end else begin
            inflight = q.size() > 0;
            expRsp = inflight && age >= 2;
            window = !inflight || (expRsp && rsp_ready);
            winner = -1;
            for (int k = 1; k <= N; k++)
                if (winner < 0 && req_valid[(ptr + k) % N]) winner = (ptr + k) % N;
            expReady = (window && winner >= 0) ? N'(1 << winner) : '0;
            check("rspValid", 64'(rsp_valid), 64'(expRsp));
            check("busy", 64'(busy), 64'(inflight));
            check("reqReady", 64'(req_ready), 64'(expReady));
            check("sticky", 64'(sticky_flags), 64'(sticky));
            check("addAB", {add_a, add_b}, {last.a, last.b});
            check("addCD", {add_c, add_d}, {last.c, last.d});
            check("addCtl", 64'({add_subop, add_rm, add_control}), 64'({last.s, last.r, ctrl_cfg}));
            for (int i = 0; i < N; i++)
                if (req_ready[i]) begin
                    dutGrants.push_back(i);
                    grantCycles.push_back(cycle);
                end
            if (expRsp) begin
                expRes = refAdd(q[0].a, q[0].b, q[0].c, q[0].d, q[0].s, q[0].r);
                check("rspId", 64'(rsp_id), 64'(q[0].id));
                check("rspData", 64'(rsp_data), 64'(expRes[31:0]));
                check("rspFlags", 64'(rsp_flags), 64'(expRes[36:32]));
            end
            if (expRsp && rsp_ready) begin
                sticky = flags_clr ? expRes[36:32] : sticky | expRes[36:32];
                void'(q.pop_front());
            end else if (flags_clr) sticky = '0;
            if (q.size() > 0) age++;
            grantMask = '0;
            if (window && winner >= 0) begin
                rec.id = winner;
                rec.a = req_a[32*winner +: 32];
                rec.b = req_b[32*winner +: 32];
                rec.c = req_c[32*winner +: 32];
                rec.d = req_d[32*winner +: 32];
                rec.s = req_subop[3*winner +: 3];
                rec.r = req_rm[3*winner +: 3];
                q.push_back(rec);
                last = rec;
                age = 1;
                ptr = winner;
                grantMask[winner] = 1'b1;
            end
        end
    end

    task automatic setReq(input int i, input logic [31:0] a, b, c, d, input logic [2:0] s, r);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_c[32*i +: 32] = c;
        req_d[32*i +: 32] = d;
        req_subop[3*i +: 3] = s;
        req_rm[3*i +: 3] = r;
        req_valid[i] = 1'b1;
    endtask

    task automatic raise(input int i);
        setReq(i, $urandom, $urandom, $urandom, $urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    endtask

    // Advance one cycle; granted requesters drop, optionally immediately posting a new op
    task automatic tick(input bit refill);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (grantMask[i]) begin
                req_valid[i] = 1'b0;
                if (refill) raise(i);
            end
    endtask

    task automatic ticks(input int n, input bit refill);
        for (int k = 0; k < n; k++) tick(refill);
    endtask

    initial begin
        ticks(3, 0);
        rst_n = 1'b1;
        // T2: all valid straight out of reset -> 0,1,2,3,0 two cycles apart
        dutGrants.delete();
        grantCycles.delete();
        for (int i = 0; i < N; i++) raise(i);
        ticks(10, 1);
        check("T2count", 64'(dutGrants.size() >= 5), 64'(1));
        for (int k = 0; k < 5 && k < dutGrants.size(); k++) begin
            check("T2order", 64'(dutGrants[k]), 64'(k % N));
            if (k > 0) check("T2spacing", 64'(grantCycles[k] - grantCycles[k-1]), 64'(2));
        end
        ticks(12, 0);
        // T1: single known sum
        setReq(0, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 3'd0, 3'd0);
        ticks(5, 0);
        // T3: consumer stalls with everyone waiting
        for (int i = 0; i < N; i++) raise(i);
        rsp_ready = 1'b0;
        ticks(9, 1);
        rsp_ready = 1'b1;
        ticks(2, 1);
        ticks(12, 0);
        // T4: overflow sticks across later ops
        flags_clr = 1'b1;
        tick(0);
        flags_clr = 1'b0;
        setReq(1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'd0, 32'd0, 3'd0, 3'd0);
        ticks(4, 0);
        raise(2);
        ticks(4, 0);
        raise(3);
        ticks(4, 0);
        @(negedge clk);
        check("T4sticky", 64'(sticky_flags & 5'b00101), 64'(5'b00101));
        // T5: clear coinciding with an inexact-only handshake
        flags_clr = 1'b1;
        setReq(0, 32'h33333333, 32'h1, 32'h2, 32'h3, 3'd0, 3'd0);
        ticks(3, 0);
        flags_clr = 1'b0;
        @(negedge clk);
        check("T5sticky", 64'(sticky_flags), 64'(5'b00001));
        ticks(4, 0);
        // T6: reset lands during EXEC; in-flight op must vanish
        for (int i = 0; i < N; i++) if (!req_valid[i]) raise(i);
        tick(1);
        rst_n = 1'b0;
        @(negedge clk);
        check("T6busy", 64'(busy), 64'(0));
        check("T6rspValid", 64'(rsp_valid), 64'(0));
        ticks(2, 0);
        rst_n = 1'b1;
        dutGrants.delete();
        ticks(2, 1);
        check("T6count", 64'(dutGrants.size() > 0), 64'(1));
        if (dutGrants.size() > 0) check("T6first", 64'(dutGrants[0]), 64'(0));
        // Random traffic with random back-pressure and clears
        for (int c = 0; c < 1500; c++) begin
            tick(0);
            for (int i = 0; i < N; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0) raise(i);
            rsp_ready = $urandom_range(0, 3) != 0;
            flags_clr = $urandom_range(0, 19) == 0;
        end
        rsp_ready = 1'b1;
        flags_clr = 1'b0;
        ticks(20, 0);
        check("drained", 64'(q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
